// File: rtl/ip_unit.sv
// Instruction-pointer unit: IP register with inc/load/call/ret/isr and a hardware return stack.
// Optional relative load on ld is enabled by defining IP_REL_BRANCH_EN.
`timescale 1ns/1ps
module ip_unit #(
  parameter int unsigned        WIDTH       = 32,
  parameter logic [WIDTH-1:0]   INC_STEP    = WIDTH'(1),
  parameter logic [WIDTH-1:0]   RESET_VEC   = '0,
  parameter logic [WIDTH-1:0]   ISR_VEC     = WIDTH'('h3FF),
  parameter int unsigned        STACK_DEPTH = 4,
  parameter int unsigned        SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic [WIDTH-1:0] ip_q,
  input  logic             oe,
  input  logic             stall,
  input  logic             inc,
  input  logic             ld,
  input  logic             call,
  input  logic             ret,
  input  logic             isr,
  input  logic             err_clr,
`ifdef IP_REL_BRANCH_EN
  input  logic             rel,
`endif
  output logic [SP_W-1:0]  sp_count,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  logic [WIDTH-1:0] ip_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [WIDTH-1:0] stack_d [STACK_DEPTH];
  logic             push;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] top;

  assign Dout      = oe ? ip_q : 'z;
  assign sp_count  = sp_q;
  assign stk_err   = err_q;
  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);

  // Entry at index sp-1 is the top of stack.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i + 1) == sp_q) top = stack_q[i];
    end
  end

  // Next-state: isr > ret > call > ld > inc; stall freezes everything including err_clr.
  always_comb begin
    ip_d     = ip_q;
    sp_d     = sp_q;
    err_d    = err_q;
    stack_d  = stack_q;
    push     = 1'b0;
    push_val = '0;
    if (!stall) begin
      if (err_clr) err_d = 1'b0;
      if (isr) begin
        ip_d = ISR_VEC;
        if (stk_full) err_d = 1'b1;
        else begin
          push     = 1'b1;
          push_val = ip_q;
        end
      end else if (ret) begin
        if (stk_empty) err_d = 1'b1;
        else begin
          ip_d = top;
          sp_d = sp_q - SP_W'(1);
        end
      end else if (call) begin
        ip_d = Din;
        if (stk_full) err_d = 1'b1;
        else begin
          push     = 1'b1;
          push_val = ip_q + INC_STEP;
        end
      end else if (ld) begin
`ifdef IP_REL_BRANCH_EN
        ip_d = rel ? (ip_q + Din) : Din;
`else
        ip_d = Din;
`endif
      end else if (inc) begin
        ip_d = ip_q + INC_STEP;
      end
      if (push) begin
        sp_d = sp_q + SP_W'(1);
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
          if (SP_W'(i) == sp_q) stack_d[i] = push_val;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ip_q    <= RESET_VEC;
      sp_q    <= '0;
      err_q   <= 1'b0;
      stack_q <= '{default: '0};
    end else begin
      ip_q    <= ip_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_ip_unit.sv
// Directed table-driven bench for ip_unit (default parameters).
`timescale 1ns/1ps
module tb_ip_unit;
  localparam int unsigned W   = 32;
  localparam int unsigned SPW = 3;

  localparam bit [6:0] S = 7'b1000000;  // stall
  localparam bit [6:0] I = 7'b0100000;  // isr
  localparam bit [6:0] R = 7'b0010000;  // ret
  localparam bit [6:0] C = 7'b0001000;  // call
  localparam bit [6:0] L = 7'b0000100;  // ld
  localparam bit [6:0] N = 7'b0000010;  // inc
  localparam bit [6:0] E = 7'b0000001;  // err_clr
  localparam bit [6:0] Z = 7'b0000000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  wire  [W-1:0]   dout;
  logic [W-1:0]   ip;
  logic           oe = 1'b0, stall = 1'b0, inc = 1'b0, ld = 1'b0, call = 1'b0;
  logic           ret = 1'b0, isr = 1'b0, err_clr = 1'b0;
`ifdef IP_REL_BRANCH_EN
  logic           rel = 1'b0;
`endif
  logic [SPW-1:0] sp;
  logic           full, empty, err;

  int checks = 0;
  int errors = 0;

  ip_unit dut (
    .Clk(clk), .Reset_n(rst_n), .Din(din), .Dout(dout), .ip_q(ip), .oe(oe),
    .stall(stall), .inc(inc), .ld(ld), .call(call), .ret(ret), .isr(isr),
    .err_clr(err_clr),
`ifdef IP_REL_BRANCH_EN
    .rel(rel),
`endif
    .sp_count(sp), .stk_full(full), .stk_empty(empty), .stk_err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit [6:0]     cmd;
    logic [W-1:0] din;
    logic [W-1:0] exp_ip;
    int unsigned  exp_sp;
    logic         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit [6:0] c, input logic [W-1:0] d, input logic [W-1:0] eip,
                     input int unsigned esp, input logic eerr);
    vec_t v;
    v.cmd = c; v.din = d; v.exp_ip = eip; v.exp_sp = esp; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit [6:0] c, input logic [W-1:0] d);
    {stall, isr, ret, call, ld, inc, err_clr} = c;
    din = d;
  endtask

  task automatic check_state(input string tag, input logic [W-1:0] eip,
                             input int unsigned esp, input logic eerr);
    check({tag, " ip"}, ip, eip);
    check({tag, " sp"}, W'(sp), W'(esp));
    check({tag, " err"}, W'(err), W'(eerr));
    check({tag, " full"}, W'(full), W'(esp == 4));
    check({tag, " empty"}, W'(empty), W'(esp == 0));
    if (oe) check({tag, " dout"}, dout, eip);
  endtask

  task automatic check_dout_off(input string tag);
    checks++;
    if (!($isunknown(dout) || dout == '0)) begin
      errors++;
      $display("FAIL %s: got %h expected Z", tag, dout);
    end
  endtask

  initial begin
    // Inc/stall
    add(N,     '0, 32'h1, 0, 0);
    add(N,     '0, 32'h2, 0, 0);
    add(N,     '0, 32'h3, 0, 0);
    add(S|N,   '0, 32'h3, 0, 0);
    add(S|L, 32'h55, 32'h3, 0, 0);
    // Wrap-around
    add(L, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0);
    add(N,     '0, 32'hFFFF_FFFF, 0, 0);
    add(N,     '0, 32'h0, 0, 0);
    add(N,     '0, 32'h1, 0, 0);
    // Call / isr / ret
    add(L, 32'h10,  32'h10,  0, 0);
    add(C, 32'h200, 32'h200, 1, 0);
    add(I,     '0,  32'h3FF, 2, 0);
    add(R,     '0,  32'h200, 1, 0);
    add(R,     '0,  32'h11,  0, 0);
    add(Z,     '0,  32'h11,  0, 0);
    // Overflow, LIFO unwind, underflow
    add(C, 32'h1000, 32'h1000, 1, 0);
    add(C, 32'h2000, 32'h2000, 2, 0);
    add(C, 32'h3000, 32'h3000, 3, 0);
    add(C, 32'h4000, 32'h4000, 4, 0);
    add(C, 32'h5000, 32'h5000, 4, 1);
    add(S|E,   '0,   32'h5000, 4, 1);
    add(I,     '0,   32'h3FF,  4, 1);
    add(R,     '0,   32'h3001, 3, 1);
    add(R,     '0,   32'h2001, 2, 1);
    add(R,     '0,   32'h1001, 1, 1);
    add(R,     '0,   32'h12,   0, 1);
    add(R,     '0,   32'h12,   0, 1);
    add(E,     '0,   32'h12,   0, 0);
    add(R|E,   '0,   32'h12,   0, 1);
    add(E,     '0,   32'h12,   0, 0);
    // Priority
    add(L, 32'h40, 32'h40, 0, 0);
    add(I|R|C|L|N, 32'h77, 32'h3FF, 1, 0);
    add(R,     '0,  32'h40, 0, 0);
    add(C|L|N, 32'h80, 32'h80, 1, 0);
    add(R|C|L, 32'h99, 32'h41, 0, 0);
    add(L|N,   32'h90, 32'h90, 0, 0);

    // Reset state
    rst_n = 1'b0;
    drive(Z, '0);
    repeat (2) @(posedge clk);
    #1;
    check_dout_off("reset dout oe0");
    oe = 1'b1;
    #1;
    check_state("reset", 32'h0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].cmd, vecs[k].din);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", k), vecs[k].exp_ip, vecs[k].exp_sp, vecs[k].exp_err);
    end
    drive(Z, '0);

    oe = 1'b0;
    #1;
    check_dout_off("dout oe0 ip90");
    oe = 1'b1;

    // Async reset mid-call sequence
    drive(C, 32'h500);
    @(posedge clk); #1;
    drive(C, 32'h600);
    @(posedge clk); #1;
    check_state("pre-reset", 32'h600, 2, 0);
    drive(N, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_state("async reset", 32'h0, 0, 0);
    @(posedge clk); #1;
    check_state("reset held", 32'h0, 0, 0);
    drive(Z, '0);
    rst_n = 1'b1;
    drive(R, '0);
    @(posedge clk); #1;
    check_state("post-reset underflow", 32'h0, 0, 1);
    drive(E, '0);
    @(posedge clk); #1;
    check_state("post-reset clr", 32'h0, 0, 0);

`ifdef IP_REL_BRANCH_EN
    drive(L, 32'h100);
    @(posedge clk); #1;
    check_state("abs ld", 32'h100, 0, 0);
    rel = 1'b1;
    drive(L, 32'hFFFF_FFF0);
    @(posedge clk); #1;
    check_state("rel ld", 32'hF0, 0, 0);
    drive(C, 32'h300);
    @(posedge clk); #1;
    check_state("rel call", 32'h300, 1, 0);
    drive(R, '0);
    @(posedge clk); #1;
    check_state("rel ret", 32'hF1, 0, 0);
    rel = 1'b0;
`endif
    drive(Z, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_unit.md
Name: ip_unit

Overview:
- Parametrised instruction-pointer unit for the bus interface unit; successor to the fixed 32-bit IP register.
- Adds configurable width, step and vectors, plus a hardware return stack for call/ret and ISR entry/return.
- Adds a stall qualifier and stack status/error flags.
- Keeps the tristate Dout onto the internal bus, and adds an always-driven copy for the fetch path.

Parameters:
- WIDTH, 32, IP width in bits.
- INC_STEP, 1, increment added on inc and used for the call return address.
- RESET_VEC, 0, IP value at reset.
- ISR_VEC, 'h3FF, interrupt service entry address.
- STACK_DEPTH, 4, return-stack entries (>=1).
- SP_W, $clog2(STACK_DEPTH+1), stack count width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Din  in  WIDTH  load / call target.
- Dout  out  WIDTH  tristate bus output: IP when oe=1, else Z.
- ip_q  out  WIDTH  IP, always driven.
- oe  in  1  bus output enable.
- stall  in  1  freeze all state this cycle.
- inc  in  1  IP <= IP + INC_STEP.
- ld  in  1  IP <= Din.
- call  in  1  push IP+INC_STEP; IP <= Din.
- ret  in  1  pop into IP.
- isr  in  1  push IP; IP <= ISR_VEC.
- err_clr  in  1  clear stk_err.
- sp_count  out  SP_W  entries in stack.
- stk_full  out  1  sp_count == STACK_DEPTH.
- stk_empty  out  1  sp_count == 0.
- stk_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (Reset_n low, asynchronous, any time including mid-sequence):
  - IP = RESET_VEC.
  - sp_count = 0 and all stack entries = 0.
  - stk_err = 0, stk_empty = 1, stk_full = 0.
  - Dout follows oe immediately: Z or RESET_VEC.
- Outputs:
  - Dout and ip_q are combinational from the IP register; no extra latency.
  - stk_full and stk_empty are combinational from sp_count.
- All commands take effect on the next rising Clk edge (1-cycle latency).
- stall=1: IP, stack and stk_err all hold; every command is ignored. err_clr is also ignored.
- Command priority when several are asserted, highest first: isr > ret > call > ld > inc. Lower-priority commands are dropped that cycle.
- No command asserted: hold.
- inc: IP <= (IP + INC_STEP) mod 2^WIDTH. Wrap-around is silent.
- ld: IP <= Din.
- call:
  - stack[sp] <= (IP + INC_STEP) mod 2^WIDTH; sp++.
  - IP <= Din.
- isr:
  - stack[sp] <= IP (current, un-incremented); sp++.
  - IP <= ISR_VEC.
- ret: IP <= stack[sp-1]; sp--.
- Overflow (call or isr while stk_full):
  - IP still updates to its target.
  - Push is dropped; stack contents and sp_count are unchanged.
  - stk_err <= 1.
- Underflow (ret while stk_empty):
  - IP holds and sp_count stays 0.
  - stk_err <= 1.
- stk_err:
  - Sticky; cleared by err_clr (not stalled) or reset.
  - If err_clr coincides with a new error in the same cycle, the error wins and stk_err = 1.
- Stack organisation:
  - LIFO; entry index = sp_count - 1 is the top.
  - Pushes and pops never happen in the same cycle (guaranteed by priority).
- sp_count ranges 0..STACK_DEPTH and never wraps.

Optional Feature:
- Macro: IP_REL_BRANCH_EN.
- Defined:
  - Adds input rel (1 bit).
  - When ld is the winning command and rel=1: IP <= (IP + Din) mod 2^WIDTH, with Din treated as two's complement.
  - When ld wins and rel=0: absolute load, as normal.
  - rel has no effect on call, ret, isr or inc.
- Not defined: no rel port; ld is always an absolute load.

Test Plan:
1. Reset and enables: Reset_n=0 then release; oe=0 → Dout=Z; oe=1 → Dout=ip_q=0, sp_count=0, stk_empty=1, stk_err=0. Then inc for 3 cycles → ip_q=3. Then stall=1 with inc=1 → ip_q stays 3.
2. Wrap-around: WIDTH=8, ld Din='hFE, then inc ×3 → IP sequence FE, FF, 00, 01. No error flag is raised.
3. Call/return: from IP='h10, call Din='h200 → IP='h200, sp_count=1. Then isr → IP='h3FF, sp_count=2. ret → IP='h200. ret → IP='h11, stk_empty=1.
4. Overflow/underflow: STACK_DEPTH=4, call ×5 → 5th call still jumps, sp_count=4, stk_full=1, stk_err=1. Then ret ×4 returns in LIFO order. A 5th ret holds IP and keeps stk_err=1. err_clr → stk_err=0.
5. Priority and error race: isr+ret+call+ld+inc all asserted at IP='h40 → IP='h3FF, stack top='h40. err_clr asserted in the same cycle as a ret on an empty stack → stk_err=1.
6. Async reset mid-call: assert Reset_n=0 between clock edges while sp_count=2 → IP=RESET_VEC and sp_count=0 immediately, without waiting for Clk. With IP_REL_BRANCH_EN defined: IP='h100, ld rel=1 Din='hFFFFFFF0 → IP='hF0.
